// File: rtl/mem_latch_pkg.sv
// Shared types and defaults for the multiplexed-AD latch/memory controller.
// Holds the FSM state encoding, default phase lengths and the phase-count helper.
package mem_latch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    HOLD = 3'd2,
    DATA = 3'd3,
    TURN = 3'd4
  } state_e;

  localparam int T_LE_DEF  = 1;
  localparam int T_ACC_DEF = 2;
  localparam int PHASE_W   = 8;

  // Phase lengths are clamped to 1..255 so the 8-bit counter can never wrap.
  function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
    int c;
    if (cycles < 1) begin
      c = 1;
    end else if (cycles > 255) begin
      c = 255;
    end else begin
      c = cycles;
    end
    return PHASE_W'(c - 1);
  endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// 8-bit loadable down-counter timing each bus phase; zero marks the last cycle.
// Decrement saturates at zero so a stray dec never wraps the count.
module bus_phase_timer
  import mem_latch_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [PHASE_W-1:0] cnt_q;
  logic [PHASE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_latch_ctrl.sv
// Controller for a memory behind a multiplexed AD bus with external address latches.
// Sequence per access: ADDR (LE high) -> HOLD -> DATA (strobe low) -> TURN (response).
module mem_latch_ctrl
  import mem_latch_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int T_LE  = T_LE_DEF,
  parameter int T_ACC = T_ACC_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [DW-1:0] ad_out,
  output logic          ad_oe,
  input  logic [DW-1:0] ad_in,
  output logic          lat_le,
  output logic          lat_oe_n,
  output logic          mem_oe_n,
  output logic          mem_we_n
);

  localparam logic [PHASE_W-1:0] LE_LOAD  = phase_load(T_LE);
  localparam logic [PHASE_W-1:0] ACC_LOAD = phase_load(T_ACC);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DW-1:0] ad_out_q, ad_out_d;
  logic          ad_oe_q, ad_oe_d;
  logic          lat_le_q, lat_le_d;
  logic          lat_oe_n_q, lat_oe_n_d;
  logic          mem_oe_n_q, mem_oe_n_d;
  logic          mem_we_n_q, mem_we_n_d;

  logic               accept;
  logic               t_load;
  logic [PHASE_W-1:0] t_val;
  logic               t_dec;
  logic               t_zero;

  bus_phase_timer u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  assign accept = req_valid && req_ready_q;

  // Next state, request capture and phase timing.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    t_load      = 1'b0;
    t_val       = LE_LOAD;
    t_dec       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ADDR;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          t_load  = 1'b1;
          t_val   = LE_LOAD;
        end
      end
      ADDR: begin
        if (t_zero) begin
          state_d = HOLD;
        end else begin
          t_dec = 1'b1;
        end
      end
      HOLD: begin
        state_d = DATA;
        t_load  = 1'b1;
        t_val   = ACC_LOAD;
      end
      DATA: begin
        if (t_zero) begin
          state_d = TURN;
          if (!we_q) begin
            rsp_rdata_d = ad_in;
          end
        end else begin
          t_dec = 1'b1;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin values are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == TURN);
    ad_out_d    = ad_out_q;
    ad_oe_d     = 1'b0;
    lat_le_d    = 1'b0;
    lat_oe_n_d  = 1'b1;
    mem_oe_n_d  = 1'b1;
    mem_we_n_d  = 1'b1;
    case (state_d)
      ADDR: begin
        ad_oe_d  = 1'b1;
        ad_out_d = DW'(addr_d);
        lat_le_d = 1'b1;
      end
      HOLD: begin
        ad_oe_d    = 1'b1;
        ad_out_d   = DW'(addr_d);
        lat_oe_n_d = 1'b0;
      end
      DATA: begin
        lat_oe_n_d = 1'b0;
        if (we_d) begin
          ad_oe_d    = 1'b1;
          ad_out_d   = wdata_d;
          mem_we_n_d = 1'b0;
        end else begin
          mem_oe_n_d = 1'b0;
        end
      end
      default: begin
        ad_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
      lat_le_q    <= 1'b0;
      lat_oe_n_q  <= 1'b1;
      mem_oe_n_q  <= 1'b1;
      mem_we_n_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      lat_le_q    <= lat_le_d;
      lat_oe_n_q  <= lat_oe_n_d;
      mem_oe_n_q  <= mem_oe_n_d;
      mem_we_n_q  <= mem_we_n_d;
    end
  end

  // Request payload is only meaningful while an access is in flight.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign lat_le    = lat_le_q;
  assign lat_oe_n  = lat_oe_n_q;
  assign mem_oe_n  = mem_oe_n_q;
  assign mem_we_n  = mem_we_n_q;

endmodule

// File: tb/tb_mem_latch_ctrl.sv
// Directed bench for mem_latch_ctrl: default-timing instance plus a T_LE=3/T_ACC=4 instance.
module tb_mem_latch_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-timing instance.
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, ad_oe, lat_le, lat_oe_n, mem_oe_n, mem_we_n;
  logic [15:0] rsp_rdata, ad_out, ad_in;
  logic [15:0] mem_rd = 16'h0000;

  assign ad_in = !mem_oe_n ? mem_rd : 16'hDEAD;

  mem_latch_ctrl dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ad_out(ad_out), .ad_oe(ad_oe),
    .ad_in(ad_in), .lat_le(lat_le), .lat_oe_n(lat_oe_n), .mem_oe_n(mem_oe_n),
    .mem_we_n(mem_we_n)
  );

  // Stretched-timing instance.
  logic        req_valid_2 = 1'b0, req_we_2 = 1'b0;
  logic [15:0] req_addr_2 = '0, req_wdata_2 = '0;
  logic        req_ready_2, rsp_valid_2, ad_oe_2, lat_le_2, lat_oe_n_2, mem_oe_n_2, mem_we_n_2;
  logic [15:0] rsp_rdata_2, ad_out_2, ad_in_2;
  logic [15:0] mem_rd_2 = 16'h0000;

  assign ad_in_2 = !mem_oe_n_2 ? mem_rd_2 : 16'hDEAD;

  mem_latch_ctrl #(.AW(16), .DW(16), .T_LE(3), .T_ACC(4)) dut2 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid_2), .req_ready(req_ready_2),
    .req_we(req_we_2), .req_addr(req_addr_2), .req_wdata(req_wdata_2),
    .rsp_valid(rsp_valid_2), .rsp_rdata(rsp_rdata_2), .ad_out(ad_out_2), .ad_oe(ad_oe_2),
    .ad_in(ad_in_2), .lat_le(lat_le_2), .lat_oe_n(lat_oe_n_2), .mem_oe_n(mem_oe_n_2),
    .mem_we_n(mem_we_n_2)
  );

  // Bus/latch model: phase lengths, latched address and protocol violations.
  int          le_cnt = 0, we_cnt = 0, oe_cnt = 0, viol = 0;
  logic [15:0] lat_addr = '0, exp_wdata = '0, prev_ad = '0;
  logic        prev_le = 1'b0;

  always @(negedge clk) begin
    if (lat_le) begin le_cnt++; lat_addr = ad_out; end
    if (!mem_we_n) begin we_cnt++; if (ad_out !== exp_wdata || !ad_oe) viol++; end
    if (!mem_oe_n) oe_cnt++;
    if (!mem_we_n && !mem_oe_n) viol++;
    if (ad_oe && !mem_oe_n) viol++;
    if (lat_le && (!mem_we_n || !mem_oe_n)) viol++;
    if (prev_le && !lat_le && (!ad_oe || ad_out !== prev_ad || lat_oe_n)) viol++;
    prev_le = lat_le;
    prev_ad = ad_out;
  end

  int          le_cnt_2 = 0, oe_cnt_2 = 0, viol_2 = 0;
  logic [15:0] lat_addr_2 = '0, prev_ad_2 = '0;
  logic        prev_le_2 = 1'b0;

  always @(negedge clk) begin
    if (lat_le_2) begin le_cnt_2++; lat_addr_2 = ad_out_2; end
    if (!mem_oe_n_2) oe_cnt_2++;
    if (!mem_we_n_2 && !mem_oe_n_2) viol_2++;
    if (ad_oe_2 && !mem_oe_n_2) viol_2++;
    if (lat_le_2 && (!mem_we_n_2 || !mem_oe_n_2)) viol_2++;
    if (prev_le_2 && !lat_le_2 && (!ad_oe_2 || ad_out_2 !== prev_ad_2 || lat_oe_n_2)) viol_2++;
    prev_le_2 = lat_le_2;
    prev_ad_2 = ad_out_2;
  end

  // One access on the default instance; lat = negedges from accept edge to rsp_valid, -1 on timeout.
  task automatic access1(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                         output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    le_cnt = 0; we_cnt = 0; oe_cnt = 0; exp_wdata = wd;
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_we = !we;
    n = 1;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    lat = rsp_valid ? n : -1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h exp 0000", rsp_rdata); end
    checks++; if (ad_oe !== 1'b0 || ad_out !== 16'h0000) begin errors++; $display("FAIL rst_ad got oe=%b out=%h exp oe=0 out=0000", ad_oe, ad_out); end
    checks++; if (lat_le !== 1'b0 || lat_oe_n !== 1'b1) begin errors++; $display("FAIL rst_latch got le=%b oe_n=%b exp le=0 oe_n=1", lat_le, lat_oe_n); end
    checks++; if (mem_oe_n !== 1'b1 || mem_we_n !== 1'b1) begin errors++; $display("FAIL rst_strobes got oe_n=%b we_n=%b exp 1 1", mem_oe_n, mem_we_n); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_write;
    int lat;
    access1(1'b1, 16'h1234, 16'hBEEF, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL wr_latency got %0d exp 5", lat); end
    checks++; if (le_cnt !== 1) begin errors++; $display("FAIL wr_le_cycles got %0d exp 1", le_cnt); end
    checks++; if (lat_addr !== 16'h1234) begin errors++; $display("FAIL wr_latched_addr got %h exp 1234", lat_addr); end
    checks++; if (we_cnt !== 2) begin errors++; $display("FAIL wr_we_cycles got %0d exp 2", we_cnt); end
    checks++; if (oe_cnt !== 0) begin errors++; $display("FAIL wr_oe_cycles got %0d exp 0", oe_cnt); end
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL wr_rdata_kept got %h exp 0000", rsp_rdata); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read;
    int lat;
    mem_rd = 16'hA5C3;
    access1(1'b0, 16'h00FF, 16'h0000, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rd_latency got %0d exp 5", lat); end
    checks++; if (oe_cnt !== 2) begin errors++; $display("FAIL rd_oe_cycles got %0d exp 2", oe_cnt); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL rd_we_cycles got %0d exp 0", we_cnt); end
    checks++; if (lat_addr !== 16'h00FF) begin errors++; $display("FAIL rd_latched_addr got %h exp 00ff", lat_addr); end
    checks++; if (rsp_rdata !== 16'hA5C3) begin errors++; $display("FAIL rd_rdata got %h exp a5c3", rsp_rdata); end
    @(negedge clk);
    access1(1'b1, 16'h0042, 16'h1111, lat);
    checks++; if (rsp_rdata !== 16'hA5C3) begin errors++; $display("FAIL rd_rdata_hold got %h exp a5c3", rsp_rdata); end
    checks++; if (lat_addr !== 16'h0042) begin errors++; $display("FAIL wr2_latched_addr got %h exp 0042", lat_addr); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int acc [3];
    int n, rsp, wait_n;
    n = 0; rsp = 0; wait_n = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    while (!req_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
    le_cnt = 0; we_cnt = 0; exp_wdata = 16'h5AA5;
    req_we = 1'b1; req_addr = 16'h3000; req_wdata = 16'h5AA5; req_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (req_valid && req_ready) begin acc[n] = i; n++; end
      if (rsp_valid) rsp++;
      @(negedge clk);
      if (n == 3) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_accepts got %0d exp 3", n); end
    checks++; if (acc[1] - acc[0] !== 6) begin errors++; $display("FAIL b2b_spacing1 got %0d exp 6", acc[1] - acc[0]); end
    checks++; if (acc[2] - acc[1] !== 6) begin errors++; $display("FAIL b2b_spacing2 got %0d exp 6", acc[2] - acc[1]); end
    checks++; if (rsp !== 3) begin errors++; $display("FAIL b2b_rsp_pulses got %0d exp 3", rsp); end
    checks++; if (we_cnt !== 6) begin errors++; $display("FAIL b2b_we_cycles got %0d exp 6", we_cnt); end
  endtask

  task automatic test_long_timing;
    int n;
    n = 0;
    while (!req_ready_2 && n < 20) begin @(negedge clk); n++; end
    le_cnt_2 = 0; oe_cnt_2 = 0; mem_rd_2 = 16'h5A5A;
    req_we_2 = 1'b0; req_addr_2 = 16'h0F0F; req_valid_2 = 1'b1;
    @(negedge clk);
    req_valid_2 = 1'b0; req_addr_2 = 16'hFFFF;
    n = 1;
    while (!rsp_valid_2 && n < 40) begin @(negedge clk); n++; end
    if (!rsp_valid_2) n = -1;
    checks++; if (n !== 9) begin errors++; $display("FAIL long_latency got %0d exp 9", n); end
    checks++; if (le_cnt_2 !== 3) begin errors++; $display("FAIL long_le_cycles got %0d exp 3", le_cnt_2); end
    checks++; if (oe_cnt_2 !== 4) begin errors++; $display("FAIL long_oe_cycles got %0d exp 4", oe_cnt_2); end
    checks++; if (lat_addr_2 !== 16'h0F0F) begin errors++; $display("FAIL long_latched_addr got %h exp 0f0f", lat_addr_2); end
    checks++; if (rsp_rdata_2 !== 16'h5A5A) begin errors++; $display("FAIL long_rdata got %h exp 5a5a", rsp_rdata_2); end
    checks++; if (viol_2 !== 0) begin errors++; $display("FAIL long_bus_protocol got %0d exp 0", viol_2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n, rsp;
    n = 0; rsp = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    exp_wdata = 16'hC0DE;
    req_we = 1'b1; req_addr = 16'h7777; req_wdata = 16'hC0DE; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (mem_we_n && n < 20) begin @(negedge clk); n++; end
    checks++; if (mem_we_n !== 1'b0) begin errors++; $display("FAIL mid_reach_data got we_n=%b exp 0", mem_we_n); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (mem_we_n !== 1'b1 || ad_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_bus got we_n=%b oe=%b exp 1 0", mem_we_n, ad_oe); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl got rsp=%b rdy=%b exp 0 0", rsp_valid, req_ready); end
    checks++; if (rsp_rdata !== 16'h0000 || lat_oe_n !== 1'b1) begin errors++; $display("FAIL mid_rst_rdata got %h oe_n=%b exp 0000 1", rsp_rdata, lat_oe_n); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b exp 1", req_ready); end
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) rsp++;
      @(negedge clk);
    end
    checks++; if (rsp !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d exp 0", rsp); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL bus_protocol got %0d exp 0", viol); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_long_timing;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_latch_ctrl.md
MEM_LATCH_CTRL -- requirements
Module: mem_latch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- AW, 16: address width, latched by external CY74FCT573 pair.
- DW, 16: data width, equal to AW, shared multiplexed AD bus.
- T_LE, 1: cycles LE held high in address phase, range 1..255.
- T_ACC, 2: cycles strobe held low in data phase, range 1..255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept.
- req_we  in  1  1=write, 0=read.
- req_addr  in  AW  access address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DW  read data, valid with rsp_valid on reads.
- ad_out  out  DW  value driven onto AD bus.
- ad_oe  out  1  1=drive AD bus, 0=high-Z (top level builds inout).
- ad_in  in  DW  AD bus sampled value.
- lat_le  out  1  latch enable, active-high transparent.
- lat_oe_n  out  1  latch output enable, active-low.
- mem_oe_n  out  1  memory read strobe, active-low.
- mem_we_n  out  1  memory write strobe, active-low.

Function
REQ-003 FSM states SHALL be IDLE, ADDR, HOLD, DATA, TURN.
REQ-004 req_ready SHALL be 1 only in IDLE; transfer accepted on clk edge with req_valid && req_ready.
REQ-005 On accept, req_we, req_addr and req_wdata SHALL be registered; later input changes ignored until next IDLE.
REQ-006 IDLE -> ADDR on accept; otherwise remain.
REQ-007 ADDR SHALL last exactly T_LE cycles: ad_oe=1, ad_out=addr, lat_le=1, lat_oe_n=1, strobes high.
REQ-008 HOLD SHALL last exactly 1 cycle: lat_le=0, ad_oe=1, ad_out=addr (address hold after LE fall), lat_oe_n=0.
REQ-009 DATA SHALL last exactly T_ACC cycles with lat_oe_n=0; write: ad_oe=1, ad_out=wdata, mem_we_n=0; read: ad_oe=0, mem_oe_n=0.
REQ-010 Read data SHALL be captured from ad_in on the clock edge ending the last DATA cycle.
REQ-011 TURN SHALL last 1 cycle: ad_oe=0, both strobes high, lat_le=0, lat_oe_n=1, rsp_valid=1; then -> IDLE.
REQ-012 rsp_rdata SHALL hold last captured read value until next read capture; on writes it is unchanged.
REQ-013 Latency SHALL be T_LE+T_ACC+2 cycles from accept edge to rsp_valid cycle (default 5); next accept no earlier than 1 cycle after TURN.
REQ-014 mem_oe_n and mem_we_n SHALL never be low simultaneously; ad_oe and mem_oe_n=0 never both asserted.
REQ-015 lat_le SHALL never be 1 outside ADDR; ad_out change while lat_le=1 SHALL not occur within one access.
REQ-016 Phase counter SHALL be 8-bit, loaded with count-1 on phase entry, phase exits at 0; no wrap.
REQ-017 All outputs SHALL be registered (no combinational path from req_* to bus pins).

Reset
REQ-018 rstn low SHALL immediately force IDLE, req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, ad_oe=0, ad_out=0, lat_le=0, lat_oe_n=1, mem_oe_n=1, mem_we_n=1, counter=0.
REQ-019 Reset mid-access SHALL abandon the access with no rsp_valid; req_ready=1 first cycle after rstn deasserts.

Structure
REQ-020 Shared package mem_latch_pkg SHALL hold the state enum and default T_LE/T_ACC constants.
REQ-021 One sub-module bus_phase_timer (8-bit loadable down-counter, zero flag) SHALL be used.

Verification
REQ-022 Write addr=0x1234 data=0xBEEF, defaults -> lat_le 1 cycle with ad=0x1234, mem_we_n low 2 cycles with ad=0xBEEF, rsp_valid 5 cycles after accept.
REQ-023 Read addr=0x00FF, model drives 0xA5C3 during DATA -> mem_oe_n low 2 cycles, ad_oe=0, rsp_rdata=0xA5C3 with rsp_valid.
REQ-024 req_valid held high, 3 back-to-back writes -> accepts spaced 6 cycles, exactly 3 rsp_valid pulses.
REQ-025 T_LE=3, T_ACC=4 read -> lat_le high 3 cycles, mem_oe_n low 4 cycles, latency 9.
REQ-026 rstn pulsed low during DATA of write -> mem_we_n=1, ad_oe=0 immediately, no rsp_valid, req_ready=1 after release.
REQ-027 Latch model checks: address at LE fall equals req_addr; strobes never overlap; no bus contention in any test.
